// File: rtl/lpm_table_ctrl.sv
// Host register front-end for the LPM route table: stages entry fields and turns
// RD_ADDR/WR_ADDR writes into single-cycle table requests, waiting (bounded) for the ack.
module lpm_table_ctrl #(
  parameter int unsigned NUM_QUEUES     = 5,
  parameter int unsigned LUT_DEPTH      = 32,
  parameter int unsigned LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
  parameter int unsigned TIMEOUT        = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reg_req,
  input  logic                      reg_rd_wr_L,
  input  logic [2:0]                reg_addr,
  input  logic [31:0]               reg_wr_data,
  output logic                      reg_ack,
  output logic [31:0]               reg_rd_data,
  output logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr,
  output logic                      lpm_rd_req,
  input  logic [31:0]               lpm_rd_ip,
  input  logic [31:0]               lpm_rd_mask,
  input  logic [NUM_QUEUES-1:0]     lpm_rd_oq,
  input  logic [31:0]               lpm_rd_next_hop_ip,
  input  logic                      lpm_rd_ack,
  output logic [LUT_DEPTH_BITS-1:0] lpm_wr_addr,
  output logic                      lpm_wr_req,
  output logic [NUM_QUEUES-1:0]     lpm_wr_oq,
  output logic [31:0]               lpm_wr_next_hop_ip,
  output logic [31:0]               lpm_wr_ip,
  output logic [31:0]               lpm_wr_mask,
  input  logic                      lpm_wr_ack
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [2:0] AddrIp     = 3'd0;
  localparam logic [2:0] AddrMask   = 3'd1;
  localparam logic [2:0] AddrNh     = 3'd2;
  localparam logic [2:0] AddrOq     = 3'd3;
  localparam logic [2:0] AddrRdAddr = 3'd4;
  localparam logic [2:0] AddrWrAddr = 3'd5;
  localparam logic [2:0] AddrStatus = 3'd6;

  typedef enum logic [1:0] {StIdle, StWrWait, StRdWait} state_e;

  state_e                    state_q, state_d;
  logic [31:0]               ip_q, ip_d, mask_q, mask_d, nh_q, nh_d;
  logic [NUM_QUEUES-1:0]     oq_q, oq_d;
  logic [LUT_DEPTH_BITS-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      timeout_err_q, timeout_err_d;
  logic                      overrun_q, overrun_d;
  logic                      range_err_q, range_err_d;
  logic [15:0]               op_count_q, op_count_d;
  logic                      reg_ack_q, reg_ack_d;
  logic [31:0]               reg_rd_data_q, reg_rd_data_d;
  logic                      lpm_rd_req_q, lpm_rd_req_d;
  logic                      lpm_wr_req_q, lpm_wr_req_d;
  logic [31:0]               rd_mux;
  logic                      addr_ok;
  logic                      wait_ack;

  assign addr_ok  = reg_wr_data < 32'(LUT_DEPTH);
  assign wait_ack = (state_q == StRdWait) ? lpm_rd_ack : lpm_wr_ack;

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      AddrIp:     rd_mux = ip_q;
      AddrMask:   rd_mux = mask_q;
      AddrNh:     rd_mux = nh_q;
      AddrOq:     rd_mux = {{(32 - NUM_QUEUES){1'b0}}, oq_q};
      AddrRdAddr: rd_mux = {{(32 - LUT_DEPTH_BITS){1'b0}}, rd_addr_q};
      AddrWrAddr: rd_mux = {{(32 - LUT_DEPTH_BITS){1'b0}}, wr_addr_q};
      AddrStatus: rd_mux = {op_count_q, 12'd0, range_err_q, overrun_q, timeout_err_q,
                            state_q != StIdle};
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ip_d          = ip_q;
    mask_d        = mask_q;
    nh_d          = nh_q;
    oq_d          = oq_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_d     = wr_addr_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    overrun_d     = overrun_q;
    range_err_d   = range_err_q;
    op_count_d    = op_count_q;
    reg_ack_d     = 1'b0;
    reg_rd_data_d = '0;
    lpm_rd_req_d  = 1'b0;
    lpm_wr_req_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (reg_req && reg_rd_wr_L) begin
          reg_ack_d     = 1'b1;
          reg_rd_data_d = rd_mux;
        end else if (reg_req) begin
          // Table requests defer the ack until the table answers; all else acks next cycle.
          reg_ack_d = 1'b1;
          case (reg_addr)
            AddrIp:   ip_d   = reg_wr_data;
            AddrMask: mask_d = reg_wr_data;
            AddrNh:   nh_d   = reg_wr_data;
            AddrOq:   oq_d   = reg_wr_data[NUM_QUEUES-1:0];
            AddrRdAddr: begin
              if (addr_ok) begin
                rd_addr_d    = reg_wr_data[LUT_DEPTH_BITS-1:0];
                lpm_rd_req_d = 1'b1;
                cnt_d        = '0;
                reg_ack_d    = 1'b0;
                state_d      = StRdWait;
              end else begin
                range_err_d = 1'b1;
              end
            end
            AddrWrAddr: begin
              if (addr_ok) begin
                wr_addr_d    = reg_wr_data[LUT_DEPTH_BITS-1:0];
                lpm_wr_req_d = 1'b1;
                cnt_d        = '0;
                reg_ack_d    = 1'b0;
                state_d      = StWrWait;
              end else begin
                range_err_d = 1'b1;
              end
            end
            AddrStatus: begin
              if (reg_wr_data[1]) timeout_err_d = 1'b0;
              if (reg_wr_data[2]) overrun_d     = 1'b0;
              if (reg_wr_data[3]) range_err_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StWrWait, StRdWait: begin
        if (reg_req) overrun_d = 1'b1;
        // An ack on the final counted cycle wins over the timeout.
        if (wait_ack) begin
          state_d    = StIdle;
          reg_ack_d  = 1'b1;
          op_count_d = op_count_q + 16'd1;
          if (state_q == StRdWait) begin
            ip_d   = lpm_rd_ip;
            mask_d = lpm_rd_mask;
            nh_d   = lpm_rd_next_hop_ip;
            oq_d   = lpm_rd_oq;
          end
        end else if (cnt_q == CntLast) begin
          state_d       = StIdle;
          reg_ack_d     = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      ip_q          <= '0;
      mask_q        <= '0;
      nh_q          <= '0;
      oq_q          <= '0;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      range_err_q   <= 1'b0;
      op_count_q    <= '0;
      reg_ack_q     <= 1'b0;
      reg_rd_data_q <= '0;
      lpm_rd_req_q  <= 1'b0;
      lpm_wr_req_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ip_q          <= ip_d;
      mask_q        <= mask_d;
      nh_q          <= nh_d;
      oq_q          <= oq_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
      range_err_q   <= range_err_d;
      op_count_q    <= op_count_d;
      reg_ack_q     <= reg_ack_d;
      reg_rd_data_q <= reg_rd_data_d;
      lpm_rd_req_q  <= lpm_rd_req_d;
      lpm_wr_req_q  <= lpm_wr_req_d;
    end
  end

  assign reg_ack            = reg_ack_q;
  assign reg_rd_data        = reg_rd_data_q;
  assign lpm_rd_addr        = rd_addr_q;
  assign lpm_rd_req         = lpm_rd_req_q;
  assign lpm_wr_addr        = wr_addr_q;
  assign lpm_wr_req         = lpm_wr_req_q;
  assign lpm_wr_ip          = ip_q;
  assign lpm_wr_mask        = mask_q;
  assign lpm_wr_next_hop_ip = nh_q;
  assign lpm_wr_oq          = oq_q;

endmodule

// File: tb/tb_lpm_table_ctrl.sv
// Randomized bench for lpm_table_ctrl: the bench plays the route table and keeps a
// register/table model to predict every host response and table request.
module tb_lpm_table_ctrl;
  localparam int unsigned NQ    = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned DB    = 5;
  localparam int unsigned TO    = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          reg_req, reg_rd_wr_L;
  logic [2:0]    reg_addr;
  logic [31:0]   reg_wr_data;
  logic          reg_ack;
  logic [31:0]   reg_rd_data;
  logic [DB-1:0] lpm_rd_addr, lpm_wr_addr;
  logic          lpm_rd_req, lpm_wr_req, lpm_rd_ack, lpm_wr_ack;
  logic [31:0]   lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip;
  logic [NQ-1:0] lpm_rd_oq, lpm_wr_oq;
  logic [31:0]   lpm_wr_next_hop_ip, lpm_wr_ip, lpm_wr_mask;

  lpm_table_ctrl #(
    .NUM_QUEUES(NQ), .LUT_DEPTH(DEPTH), .LUT_DEPTH_BITS(DB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_ack(reg_ack),
    .reg_rd_data(reg_rd_data), .lpm_rd_addr(lpm_rd_addr), .lpm_rd_req(lpm_rd_req),
    .lpm_rd_ip(lpm_rd_ip), .lpm_rd_mask(lpm_rd_mask), .lpm_rd_oq(lpm_rd_oq),
    .lpm_rd_next_hop_ip(lpm_rd_next_hop_ip), .lpm_rd_ack(lpm_rd_ack),
    .lpm_wr_addr(lpm_wr_addr), .lpm_wr_req(lpm_wr_req), .lpm_wr_oq(lpm_wr_oq),
    .lpm_wr_next_hop_ip(lpm_wr_next_hop_ip), .lpm_wr_ip(lpm_wr_ip),
    .lpm_wr_mask(lpm_wr_mask), .lpm_wr_ack(lpm_wr_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: staging registers, status, and the route table contents.
  logic [31:0]   m_ip, m_mask, m_nh;
  logic [NQ-1:0] m_oq;
  logic [DB-1:0] m_rd_addr, m_wr_addr;
  logic          m_to, m_ov, m_rg;
  logic [15:0]   m_cnt;
  logic [31:0]   t_ip [DEPTH];
  logic [31:0]   t_mask [DEPTH];
  logic [31:0]   t_nh [DEPTH];
  logic [NQ-1:0] t_oq [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ip = '0; m_mask = '0; m_nh = '0; m_oq = '0;
    m_rd_addr = '0; m_wr_addr = '0;
    m_to = 1'b0; m_ov = 1'b0; m_rg = 1'b0; m_cnt = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_ip;
      3'd1:    return m_mask;
      3'd2:    return m_nh;
      3'd3:    return 32'(m_oq);
      3'd4:    return 32'(m_rd_addr);
      3'd5:    return 32'(m_wr_addr);
      3'd6:    return {m_cnt, 12'd0, m_rg, m_ov, m_to, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  // One host access. lat: cycle (after reg_req) in which the table acks, 0 = never.
  // noise_k: cycle of a mismatched ack; ov_k: cycle of an extra host write while busy.
  task automatic do_op(input string tag, input bit rw, input logic [2:0] addr,
                       input logic [31:0] data, input int lat, input int noise_k,
                       input int ov_k_in, output logic [31:0] rdata);
    bit            is_tbl, is_rd, ok;
    int            exp_ack, ov_k, ack_cyc, n_ack, n_wrq, n_rdq, req_cyc;
    logic [DB-1:0] a, q_addr;
    logic [31:0]   e_rdata, q_ip, q_mask, q_nh;
    logic [NQ-1:0] q_oq;
    is_tbl  = !rw && (addr == 3'd4 || addr == 3'd5) && data < DEPTH;
    is_rd   = (addr == 3'd4);
    a       = data[DB-1:0];
    ok      = is_tbl && lat >= 1 && lat <= TO;
    exp_ack = !is_tbl ? 1 : (ok ? lat + 1 : TO + 1);
    ov_k    = (is_tbl && ov_k_in >= 1 && ov_k_in < exp_ack) ? ov_k_in : 0;
    e_rdata = rw ? m_read(addr) : 32'd0;
    ack_cyc = -1; n_ack = 0; n_wrq = 0; n_rdq = 0; req_cyc = -1; rdata = '0;
    q_addr = '0; q_ip = '0; q_mask = '0; q_nh = '0; q_oq = '0;

    reg_req = 1'b1; reg_rd_wr_L = rw; reg_addr = addr; reg_wr_data = data;
    tick();
    reg_req = 1'b0; reg_wr_data = $urandom;
    for (int k = 1; k <= int'(TO) + 6; k++) begin
      if (reg_ack) begin
        n_ack++;
        if (ack_cyc < 0) begin ack_cyc = k; rdata = reg_rd_data; end
      end
      if (lpm_wr_req) begin
        n_wrq++; req_cyc = k; q_addr = lpm_wr_addr;
        q_ip = lpm_wr_ip; q_mask = lpm_wr_mask; q_nh = lpm_wr_next_hop_ip; q_oq = lpm_wr_oq;
      end
      if (lpm_rd_req) begin n_rdq++; req_cyc = k; q_addr = lpm_rd_addr; end
      if (ack_cyc > 0 && k > ack_cyc) break;
      lpm_wr_ack = (is_tbl && !is_rd && k == lat) || (is_rd && k == noise_k);
      lpm_rd_ack = (is_tbl && is_rd && k == lat) || (!is_rd && k == noise_k);
      if (is_tbl && is_rd && k == lat) begin
        lpm_rd_ip = t_ip[a]; lpm_rd_mask = t_mask[a];
        lpm_rd_next_hop_ip = t_nh[a]; lpm_rd_oq = t_oq[a];
      end else begin
        lpm_rd_ip = $urandom; lpm_rd_mask = $urandom;
        lpm_rd_next_hop_ip = $urandom; lpm_rd_oq = NQ'($urandom);
      end
      reg_req = (k == ov_k);
      if (k == ov_k) begin reg_rd_wr_L = 1'b0; reg_addr = 3'd0; reg_wr_data = $urandom; end
      tick();
    end
    reg_req = 1'b0; lpm_wr_ack = 1'b0; lpm_rd_ack = 1'b0;

    check({tag, "/ack_cycle"}, ack_cyc, exp_ack);
    check({tag, "/ack_count"}, n_ack, 1);
    if (rw) check({tag, "/rd_data"}, rdata, e_rdata);
    check({tag, "/wr_req_count"}, n_wrq, (is_tbl && !is_rd) ? 1 : 0);
    check({tag, "/rd_req_count"}, n_rdq, (is_tbl && is_rd) ? 1 : 0);
    if (is_tbl) begin
      check({tag, "/req_cycle"}, req_cyc, 1);
      check({tag, "/req_addr"}, 32'(q_addr), 32'(a));
      if (!is_rd) begin
        check({tag, "/wr_ip"}, q_ip, m_ip);
        check({tag, "/wr_mask"}, q_mask, m_mask);
        check({tag, "/wr_nh"}, q_nh, m_nh);
        check({tag, "/wr_oq"}, 32'(q_oq), 32'(m_oq));
      end
    end

    if (!rw) begin
      case (addr)
        3'd0: m_ip = data;
        3'd1: m_mask = data;
        3'd2: m_nh = data;
        3'd3: m_oq = data[NQ-1:0];
        3'd4: if (data < DEPTH) m_rd_addr = a; else m_rg = 1'b1;
        3'd5: if (data < DEPTH) m_wr_addr = a; else m_rg = 1'b1;
        3'd6: begin
          if (data[1]) m_to = 1'b0;
          if (data[2]) m_ov = 1'b0;
          if (data[3]) m_rg = 1'b0;
        end
        default: ;
      endcase
    end
    if (is_tbl) begin
      if (ok) begin
        m_cnt++;
        if (is_rd) begin
          m_ip = t_ip[a]; m_mask = t_mask[a]; m_nh = t_nh[a]; m_oq = t_oq[a];
        end else begin
          t_ip[a] = m_ip; t_mask[a] = m_mask; t_nh[a] = m_nh; t_oq[a] = m_oq;
        end
      end else begin
        m_to = 1'b1;
      end
    end
    if (ov_k > 0) m_ov = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    int          n_ack;
    int          r, lat, nk, ov;
    logic [2:0]  ad;
    logic [31:0] dt;

    reset = 1'b1; reg_req = 1'b0; reg_rd_wr_L = 1'b0; reg_addr = '0; reg_wr_data = '0;
    lpm_rd_ack = 1'b0; lpm_wr_ack = 1'b0;
    lpm_rd_ip = '0; lpm_rd_mask = '0; lpm_rd_next_hop_ip = '0; lpm_rd_oq = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      t_ip[i] = $urandom; t_mask[i] = $urandom; t_nh[i] = $urandom; t_oq[i] = NQ'($urandom);
    end
    model_reset();
    repeat (3) tick();
    reset = 1'b0;

    check("rst/reg_ack", 32'(reg_ack), 0);
    check("rst/rd_req", 32'(lpm_rd_req), 0);
    check("rst/wr_req", 32'(lpm_wr_req), 0);
    check("rst/rd_data", reg_rd_data, 0);
    check("rst/wr_ip", lpm_wr_ip, 0);
    check("rst/wr_mask", lpm_wr_mask, 0);
    check("rst/wr_nh", lpm_wr_next_hop_ip, 0);
    check("rst/wr_oq", 32'(lpm_wr_oq), 0);
    check("rst/addrs", {lpm_rd_addr, lpm_wr_addr}, 0);
    do_op("rst/status", 1'b1, 3'd6, 0, 0, 0, 0, rd);
    check("rst/status_val", rd, 32'h0);

    // Table write of a prepared entry, table acks 16 cycles after the host access.
    do_op("tp1/ip", 1'b0, 3'd0, 32'h0A000000, 0, 0, 0, rd);
    do_op("tp1/mask", 1'b0, 3'd1, 32'hFF000000, 0, 0, 0, rd);
    do_op("tp1/nh", 1'b0, 3'd2, 32'h0A000001, 0, 0, 0, rd);
    do_op("tp1/oq", 1'b0, 3'd3, 32'h4, 0, 0, 0, rd);
    do_op("tp1/wr", 1'b0, 3'd5, 32'd3, 16, 0, 0, rd);
    check("tp1/t3_ip", t_ip[3], 32'h0A000000);
    do_op("tp1/status", 1'b1, 3'd6, 0, 0, 0, 0, rd);
    check("tp1/status_val", rd, 32'h00010000);

    // Table read with one-cycle table latency.
    t_ip[7] = 32'hC0A80000; t_mask[7] = 32'hFFFF0000; t_oq[7] = 5'h01; t_nh[7] = 32'h0;
    do_op("tp2/rd", 1'b0, 3'd4, 32'd7, 1, 0, 0, rd);
    do_op("tp2/ip", 1'b1, 3'd0, 0, 0, 0, 0, rd);   check("tp2/ip_val", rd, 32'hC0A80000);
    do_op("tp2/mask", 1'b1, 3'd1, 0, 0, 0, 0, rd); check("tp2/mask_val", rd, 32'hFFFF0000);
    do_op("tp2/nh", 1'b1, 3'd2, 0, 0, 0, 0, rd);   check("tp2/nh_val", rd, 32'h0);
    do_op("tp2/oq", 1'b1, 3'd3, 0, 0, 0, 0, rd);   check("tp2/oq_val", rd, 32'h1);
    do_op("tp2/status", 1'b1, 3'd6, 0, 0, 0, 0, rd);
    check("tp2/count", 32'(rd[31:16]), 2);

    // No table ack: timeout, then clear timeout_err.
    do_op("tp3/wr", 1'b0, 3'd5, 32'd5, 0, 0, 0, rd);
    do_op("tp3/status", 1'b1, 3'd6, 0, 0, 0, 0, rd);
    check("tp3/timeout_err", 32'(rd[1]), 1);
    check("tp3/count", 32'(rd[31:16]), 2);
    do_op("tp3/clr", 1'b0, 3'd6, 32'h2, 0, 0, 0, rd);
    do_op("tp3/status2", 1'b1, 3'd6, 0, 0, 0, 0, rd);
    check("tp3/timeout_clr", 32'(rd[1]), 0);

    // Out-of-range read address.
    do_op("tp4/rd", 1'b0, 3'd4, DEPTH, 5, 0, 0, rd);
    do_op("tp4/status", 1'b1, 3'd6, 0, 0, 0, 0, rd);
    check("tp4/range_err", 32'(rd[3]), 1);
    do_op("tp4/rdaddr", 1'b1, 3'd4, 0, 0, 0, 0, rd);
    check("tp4/rdaddr_val", rd, 7);

    // Dropped write during RD_WAIT, ack on the last cycle before timeout.
    do_op("tp5/rd", 1'b0, 3'd4, 32'd9, int'(TO), 0, 3, rd);
    do_op("tp5/status", 1'b1, 3'd6, 0, 0, 0, 0, rd);
    check("tp5/ov_to", 32'(rd[2:1]), 32'h2);
    do_op("tp5/ip", 1'b1, 3'd0, 0, 0, 0, 0, rd);
    check("tp5/ip_latched", rd, t_ip[9]);

    // Reset in the middle of a table read; a late ack must be ignored.
    reg_req = 1'b1; reg_rd_wr_L = 1'b0; reg_addr = 3'd4; reg_wr_data = 32'd2;
    tick();
    reg_req = 1'b0;
    n_ack = 0;
    repeat (3) begin if (reg_ack) n_ack++; tick(); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (reg_ack) n_ack++;
      lpm_rd_ack = (k == 1);
      lpm_rd_ip = t_ip[2]; lpm_rd_mask = t_mask[2];
      lpm_rd_next_hop_ip = t_nh[2]; lpm_rd_oq = t_oq[2];
      tick();
    end
    lpm_rd_ack = 1'b0;
    check("rst_mid/no_ack", n_ack, 0);
    model_reset();
    for (int i = 0; i < 7; i++) do_op("rst_mid/rd", 1'b1, 3'(i), 0, 0, 0, 0, rd);

    // Randomized traffic.
    repeat (250) begin
      r = $urandom_range(0, 99); lat = 0; nk = 0; ov = 0;
      if (r < 30) begin
        ad = 3'($urandom_range(0, 3)); dt = $urandom;
        do_op("rnd/wr", 1'b0, ad, dt, 0, $urandom_range(0, 3), 0, rd);
      end else if (r < 50) begin
        ad = 3'($urandom_range(0, 7));
        do_op("rnd/rd", 1'b1, ad, 0, 0, $urandom_range(0, 3), 0, rd);
      end else if (r < 56) begin
        ad = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'd6;
        do_op("rnd/status_wr", 1'b0, ad, $urandom, 0, 0, 0, rd);
      end else begin
        ad = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd5;
        dt = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 1000) : $urandom_range(0, 31);
        r = $urandom_range(0, 9);
        lat = (r == 0) ? 0 : (r == 1) ? int'(TO) : $urandom_range(1, 20);
        nk = $urandom_range(0, 25);
        if ($urandom_range(0, 3) == 0) ov = $urandom_range(1, (lat > 0) ? lat : int'(TO));
        do_op("rnd/tbl", 1'b0, ad, dt, lat, nk, ov, rd);
      end
    end
    for (int i = 0; i < 7; i++) do_op("final/rd", 1'b1, 3'(i), 0, 0, 0, 0, rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
